instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- In-order instruction buffer ahead of the decoder; presents one instruction per cycle on the decoder's `instr` input.
- Holds up to DEPTH fetched instructions.
- Classifies the head as ADD-class (ALU, load/store) or MUL-class.
- Issues the head only when the target reservation station reports a free row; otherwise presents the idle word.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- IW, 32, instruction width.
- CW, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  fetch offers push_instr this cycle.
- push_instr  in  IW  instruction to enqueue.
- full  out  1  count == DEPTH.
- count  out  CW  current occupancy.
- add_rs_free  in  1  ADD reservation station has at least one free row.
- mul_rs_free  in  1  MUL reservation station has at least one free row.
- instr  out  IW  registered instruction to the decoder; 32'h0000_0000 when idle.
- issue_valid  out  1  instr holds a real instruction this cycle.
- illegal  out  1  one-cycle pulse: head had an unsupported opcode and was dropped.

Interface (already decided):
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset low, asynchronous): head=tail=0, count=0, full=0, instr=0, issue_valid=0, illegal=0, hold-off flags cleared.
- Reset asserted mid-operation discards all entries; no partial issue.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
- Classification of the head word (opcode = [6:0]):
  - 0110011 with funct7 0000001: MUL.
  - 0110011 with any other funct7: ADD.
  - 0010011, 0000011, 0100011: ADD.
  - Anything else: ILLEGAL.
- Issue condition (combinational on registered state): count!=0, and either
  - class ADD and add_rs_free and !add_hold, or
  - class MUL and mul_rs_free and !mul_hold.
- On issue:
  - At the clock edge: instr <= head word, issue_valid <= 1, head advances, count decrements.
  - add_hold or mul_hold (matching class) is set for exactly the next cycle. This covers the one-cycle lag of RS free reporting.
- No issue: instr <= 0 and issue_valid <= 0 at the edge.
- ILLEGAL head: popped at the edge without issue, instr <= 0, illegal <= 1 for one cycle. No hold-off is set.
- Push acceptance: accepted iff count<DEPTH, or a pop (issue or drop) happens in the same cycle.
  - A push while full with no pop is ignored; the entry is lost and the queue is unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: an entry pushed at edge N is at the head after edge N; earliest instr presentation is edge N+1. No bypass.
- Empty queue: instr=0, issue_valid=0, no hold-offs set.
- Ordering: strictly in order. A stalled MUL blocks younger ADDs.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- When defined, adds outputs:
  - stall_cycles (32 bit): counts cycles with count!=0 and no issue or drop.
  - issued_add (32 bit) and issued_mul (32 bit): per-class issue totals.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package `tomasulo_pkg`:
  - Opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE.
  - FUNCT7_MUL.
  - IDLE_INSTR = 32'h0.
  - `instr_class_t` enum {CLS_ADD, CLS_MUL, CLS_ILLEGAL}.
- Sub-module `instr_classify`: combinational, IW-bit word in, instr_class_t out. Reusable by the decoder.

Test Plan:
1. Reset low, then release; push 32'h0020_81B3 (add) with add_rs_free=1 -> next edge count=1, following edge instr=32'h0020_81B3, issue_valid=1, count=0.
2. Push mul 32'h0220_81B3 then add; mul_rs_free=0 for 5 cycles -> instr=0 for those cycles (add blocked behind mul); mul_rs_free=1 -> mul issues, then add issues one cycle later.
3. Push 9 words back-to-back with both free=0, DEPTH=8 -> full=1 after 8th; 9th is dropped; release both -> exactly 8 issued in push order.
4. Two consecutive adds, add_rs_free held 1 -> first issues, next cycle instr=0 (hold-off), third cycle second add issues.
5. Push 32'h0000_007F (illegal) -> illegal pulses once, issue_valid stays 0, count returns to 0.
6. Queue holds 4 entries while issuing; assert reset low mid-stream -> count=0, instr=0, issue_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// +--------------------------------------------------------------------+
// | tomasulo_pkg: opcode constants, idle word and instruction classes. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package tomasulo_pkg;

  localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
  localparam logic [6:0]  OP_ITYPE   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [6:0]  FUNCT7_MUL = 7'b0000001;
  localparam logic [31:0] IDLE_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLS_ADD     = 2'd0,
    CLS_MUL     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/instr_classify.sv
// +--------------------------------------------------------------------+
// | instr_classify: maps an instruction word to ADD / MUL / ILLEGAL.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_classify
  import tomasulo_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] word,
  output instr_class_t  cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    casez (word[31:0])
      {FUNCT7_MUL, 18'b?, OP_RTYPE}: cls = CLS_MUL;
      {25'b?, OP_RTYPE}:             cls = CLS_ADD;
      {25'b?, OP_ITYPE}:             cls = CLS_ADD;
      {25'b?, OP_LOAD}:              cls = CLS_ADD;
      {25'b?, OP_STORE}:             cls = CLS_ADD;
      default:                       cls = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_issue_queue.sv
// +--------------------------------------------------------------------+
// | instr_issue_queue: in-order issue buffer gated by RS free flags.   |
// | Optional ISSUE_STATS_EN adds stall / per-class issue counters.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [IW-1:0] push_instr,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic          add_rs_free,
  input  logic          mul_rs_free,
  output logic [IW-1:0] instr,
  output logic          issue_valid,
`ifdef ISSUE_STATS_EN
  output logic [31:0]   stall_cycles,
  output logic [31:0]   issued_add,
  output logic [31:0]   issued_mul,
`endif
  output logic          illegal
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [IW-1:0] C_IDLE  = IW'(IDLE_INSTR);

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          issue_valid_q, issue_valid_d;
  logic          illegal_q, illegal_d;
  logic          add_hold_q, add_hold_d, mul_hold_q, mul_hold_d;

  logic [IW-1:0] head_word;
  instr_class_t  head_cls;
  logic          nonempty, do_issue, do_drop, do_pop, do_push;

  assign head_word = mem_q[head_q];

  instr_classify #(.IW(IW)) u_classify (
    .word (head_word),
    .cls  (head_cls)
  );

  always_comb begin
    nonempty = (count_q != '0);
    do_issue = nonempty &&
               ((head_cls == CLS_ADD && add_rs_free && !add_hold_q) ||
                (head_cls == CLS_MUL && mul_rs_free && !mul_hold_q));
    do_drop  = nonempty && (head_cls == CLS_ILLEGAL);
    do_pop   = do_issue || do_drop;
    // A full queue still takes a push when the head leaves this cycle.
    do_push  = push && ((count_q != C_DEPTH) || do_pop);

    head_d = do_pop  ? head_q + 1'b1 : head_q;
    tail_d = do_push ? tail_q + 1'b1 : tail_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    instr_d       = do_issue ? head_word : C_IDLE;
    issue_valid_d = do_issue;
    illegal_d     = do_drop;
    // RS free flags lag one cycle, so block the same class right after issue.
    add_hold_d    = do_issue && (head_cls == CLS_ADD);
    mul_hold_d    = do_issue && (head_cls == CLS_MUL);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      instr_q       <= C_IDLE;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      add_hold_q    <= 1'b0;
      mul_hold_q    <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
      add_hold_q    <= add_hold_d;
      mul_hold_q    <= mul_hold_d;
    end
  end

  assign full        = (count_q == C_DEPTH);
  assign count       = count_q;
  assign instr       = instr_q;
  assign issue_valid = issue_valid_q;
  assign illegal     = illegal_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] stall_q, stall_d, add_cnt_q, add_cnt_d, mul_cnt_q, mul_cnt_d;

  always_comb begin
    stall_d   = stall_q;
    add_cnt_d = add_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if (nonempty && !do_pop && stall_q != '1)
      stall_d = stall_q + 32'd1;
    if (do_issue && head_cls == CLS_ADD && add_cnt_q != '1)
      add_cnt_d = add_cnt_q + 32'd1;
    if (do_issue && head_cls == CLS_MUL && mul_cnt_q != '1)
      mul_cnt_d = mul_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      add_cnt_q <= '0;
      mul_cnt_q <= '0;
    end else begin
      stall_q   <= stall_d;
      add_cnt_q <= add_cnt_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_add   = add_cnt_q;
  assign issued_mul   = mul_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
// +--------------------------------------------------------------------+
// | tb_instr_issue_queue: directed + random stimulus vs. queue model.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_issue_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [31:0] push_instr = '0;
  logic        add_rs_free = 1'b0;
  logic        mul_rs_free = 1'b0;
  logic        full;
  logic [3:0]  count;
  logic [31:0] instr;
  logic        issue_valid;
  logic        illegal;
`ifdef ISSUE_STATS_EN
  logic [31:0] stall_cycles, issued_add, issued_mul;
`endif

  instr_issue_queue #(.DEPTH(DEPTH), .IW(32)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .push        (push),
    .push_instr  (push_instr),
    .full        (full),
    .count       (count),
    .add_rs_free (add_rs_free),
    .mul_rs_free (mul_rs_free),
    .instr       (instr),
    .issue_valid (issue_valid),
`ifdef ISSUE_STATS_EN
    .stall_cycles(stall_cycles),
    .issued_add  (issued_add),
    .issued_mul  (issued_mul),
`endif
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a plain queue of pending words plus the last-cycle outputs.
  logic [31:0] m_q[$];
  logic [31:0] m_instr;
  bit          m_valid, m_ill, m_add_hold, m_mul_hold;
  int unsigned m_stall, m_nadd, m_nmul;

  function automatic int ref_class(input logic [31:0] w);
    if (w[6:0] == 7'h33) return (w[31:25] == 7'd1) ? 1 : 0;
    if (w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h23) return 0;
    return 2;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_instr = '0; m_valid = 0; m_ill = 0; m_add_hold = 0; m_mul_hold = 0;
    m_stall = 0; m_nadd = 0; m_nmul = 0;
  endtask

  task automatic model_step();
    logic [31:0] hw;
    int cls;
    bit have, iss, drp, pop, acc;
    have = (m_q.size() != 0);
    hw   = have ? m_q[0] : 32'h0;
    cls  = have ? ref_class(hw) : 0;
    iss  = have && ((cls == 0 && add_rs_free && !m_add_hold) ||
                    (cls == 1 && mul_rs_free && !m_mul_hold));
    drp  = have && cls == 2;
    pop  = iss || drp;
    acc  = push && (m_q.size() < DEPTH || pop);
    if (have && !pop) m_stall++;
    if (iss && cls == 0) m_nadd++;
    if (iss && cls == 1) m_nmul++;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(push_instr);
    m_instr    = iss ? hw : 32'h0;
    m_valid    = iss;
    m_ill      = drp;
    m_add_hold = iss && cls == 0;
    m_mul_hold = iss && cls == 1;
  endtask

  task automatic compare_all();
    check_eq("count", 32'(count), 32'(m_q.size()));
    check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
    check_eq("instr", instr, m_instr);
    check_eq("issue_valid", 32'(issue_valid), 32'(m_valid));
    check_eq("illegal", 32'(illegal), 32'(m_ill));
`ifdef ISSUE_STATS_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
    check_eq("issued_add", issued_add, m_nadd);
    check_eq("issued_mul", issued_mul, m_nmul);
`endif
  endtask

  // Called at a negedge: drive inputs, advance the model, check after the next posedge.
  task automatic step(input bit p, input logic [31:0] w, input bit af, input bit mf);
    push = p; push_instr = w; add_rs_free = af; mul_rs_free = mf;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: begin w[6:0] = 7'h33; if (w[31:25] == 7'd1) w[31:25] = 7'd0; end
      1: begin w[6:0] = 7'h33; w[31:25] = 7'd1; end
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      default: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h7F;
    endcase
    return w;
  endfunction

  initial begin
    model_reset();
    #12;
    compare_all();
    check_eq("reset_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single add: enqueued, then issued on the following edge.
    step(1, 32'h0020_81B3, 1, 0);
    check_eq("t1_count", 32'(count), 32'd1);
    step(0, 32'h0, 1, 0);
    check_eq("t1_instr", instr, 32'h0020_81B3);
    check_eq("t1_valid", 32'(issue_valid), 32'd1);

    // Stalled mul blocks the younger add.
    step(1, 32'h0220_81B3, 1, 0);
    step(1, 32'h0040_0113, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 0);
    check_eq("t2_blocked", 32'(issue_valid), 32'd0);
    step(0, 32'h0, 1, 1);
    check_eq("t2_mul", instr, 32'h0220_81B3);
    step(0, 32'h0, 1, 1);
    check_eq("t2_add", instr, 32'h0040_0113);

    // Nine pushes into an eight-deep queue; the last is lost.
    for (int i = 0; i < 9; i++) begin
      step(1, {20'(i + 1), 5'd1, 7'h13}, 0, 0);
      if (i == 7) check_eq("t3_full", 32'(full), 32'd1);
    end
    check_eq("t3_count", 32'(count), 32'd8);
    for (int i = 0; i < 18; i++) step(0, 32'h0, 1, 1);

    // Back-to-back adds with the add hold-off.
    step(1, 32'h0010_0093, 0, 0);
    step(1, 32'h0020_0113, 0, 0);
    step(0, 32'h0, 1, 1);
    step(0, 32'h0, 1, 1);
    check_eq("t4_hold", 32'(issue_valid), 32'd0);
    step(0, 32'h0, 1, 1);
    check_eq("t4_second", instr, 32'h0020_0113);

    // Illegal opcode is dropped with a single pulse.
    step(1, 32'h0000_007F, 1, 1);
    step(0, 32'h0, 1, 1);
    check_eq("t5_illegal", 32'(illegal), 32'd1);
    check_eq("t5_count", 32'(count), 32'd0);
    step(0, 32'h0, 1, 1);
    check_eq("t5_pulse", 32'(illegal), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, rand_word(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 5; i++) step(1, 32'h0030_0193 + 32'(i << 20), 0, 0);
    step(0, 32'h0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_count", 32'(count), 32'd0);
    check_eq("t6_instr", instr, 32'h0);
    check_eq("t6_valid", 32'(issue_valid), 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) != 0, rand_word(),
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
